// File: rtl/idu_sched_pkg.sv
// Shared types for the decode-stage scheduler.
// Flush FSM states and register index width.
package idu_sched_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    SCHED_IDLE,
    SCHED_FLUSH
  } sched_state_e;

endpackage

// File: rtl/idu_sched_if.sv
// Decode/writeback/branch inputs and stall/flush outputs
// between IDU1 decode and the scheduler.
interface idu_sched_if;
  import idu_sched_pkg::*;

  logic                  dec_valid;
  logic                  dec_rs1;
  logic [REG_ADDR_W-1:0] dec_rs1_addr;
  logic                  dec_rs2;
  logic [REG_ADDR_W-1:0] dec_rs2_addr;
  logic                  dec_rd;
  logic [REG_ADDR_W-1:0] dec_rd_addr;
  logic                  dec_load;
  logic                  dec_div;
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd_addr;
  logic                  mispredict;
  logic                  pipe_stall;
  logic                  pipe_flush;
  logic                  div_busy;

  modport master (
    output dec_valid, dec_rs1, dec_rs1_addr,
    output dec_rs2, dec_rs2_addr,
    output dec_rd, dec_rd_addr,
    output dec_load, dec_div,
    output wb_valid, wb_rd_addr, mispredict,
    input  pipe_stall, pipe_flush, div_busy
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs1_addr,
    input  dec_rs2, dec_rs2_addr,
    input  dec_rd, dec_rd_addr,
    input  dec_load, dec_div,
    input  wb_valid, wb_rd_addr, mispredict,
    output pipe_stall, pipe_flush, div_busy
  );

endinterface

// File: rtl/idu_scoreboard.sv
// Pending-writeback scoreboard for long-latency results.
// Writeback in the same cycle releases the hazard.
module idu_scoreboard
  import idu_sched_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic                  rs1_en,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic                  rs2_en,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  rd_en,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  hazard
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] clr;
  logic [NUM_REGS-1:0] set;
  logic [NUM_REGS-1:0] eff;
  logic [NUM_REGS-1:0] nxt;

  // set/clear masks, bypassed view and hazard lookup
  always_comb begin
    clr = '0;
    set = '0;
    if (wb_valid) clr[wb_addr] = 1'b1;
    if (set_en && set_addr != '0) set[set_addr] = 1'b1;
    eff = pending & ~clr;
    nxt = eff | set;
    nxt[0] = 1'b0;
    hazard = (rs1_en && rs1_addr != '0 && eff[rs1_addr])
          || (rs2_en && rs2_addr != '0 && eff[rs2_addr])
          || (rd_en  && rd_addr  != '0 && eff[rd_addr]);
  end

  // pending vector; a set beats a same-index clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= nxt;
  end

endmodule

// File: rtl/idu_sched.sv
// Decode-stage scheduler: RAW/WAW and divider stalls,
// multi-cycle flush after a branch mispredict.
module idu_sched
  import idu_sched_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int DIV_LAT      = 34,
  parameter int FLUSH_CYCLES = 2
) (
  input logic        clk,
  input logic        rst_n,
  idu_sched_if.slave bus
);

  localparam int DIV_W = $clog2(DIV_LAT);
  localparam int FLS_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(DIV_LAT - 1);
  localparam logic [FLS_W-1:0] FLS_LOAD = FLS_W'(FLUSH_CYCLES - 1);
  localparam logic [FLS_W-1:0] FLS_ONE  = FLS_W'(1);

  logic             sb_hazard;
  logic             hazard;
  logic             stall;
  logic             flush;
  logic             issue;
  logic             busy;
  logic [DIV_W-1:0] div_cnt;
  sched_state_e     state_q, state_d;
  logic [FLS_W-1:0] cnt_q, cnt_d;

  idu_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (issue & bus.dec_rd & (bus.dec_load | bus.dec_div)),
    .set_addr (bus.dec_rd_addr),
    .wb_valid (bus.wb_valid),
    .wb_addr  (bus.wb_rd_addr),
    .rs1_en   (bus.dec_rs1),
    .rs1_addr (bus.dec_rs1_addr),
    .rs2_en   (bus.dec_rs2),
    .rs2_addr (bus.dec_rs2_addr),
    .rd_en    (bus.dec_rd),
    .rd_addr  (bus.dec_rd_addr),
    .hazard   (sb_hazard)
  );

  // flush overrides stall; issue only when neither holds
  always_comb begin
    busy   = div_cnt != '0;
    hazard = sb_hazard | (bus.dec_div & busy);
    flush  = bus.mispredict | (state_q == SCHED_FLUSH);
    stall  = bus.dec_valid & hazard & ~flush;
    issue  = bus.dec_valid & ~stall & ~flush;
  end

  assign bus.pipe_stall = stall;
  assign bus.pipe_flush = flush;
  assign bus.div_busy   = busy;

  // divider occupancy countdown from issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 div_cnt <= '0;
    else if (issue && bus.dec_div) div_cnt <= DIV_LOAD;
    else if (div_cnt != '0)     div_cnt <= div_cnt - 1'b1;
  end

  // cnt_q holds FLUSH-state cycles still owed, this one included
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SCHED_IDLE: begin
        if (bus.mispredict && FLUSH_CYCLES > 1) begin
          state_d = SCHED_FLUSH;
          cnt_d   = FLS_LOAD;
        end
      end
      SCHED_FLUSH: begin
        if (bus.mispredict) begin
          cnt_d = FLS_LOAD;
        end else if (cnt_q <= FLS_ONE) begin
          state_d = SCHED_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = SCHED_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // flush FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCHED_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
